// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundle of the producer handshakes and the register-bank
// write port seen by the write-back arbiter.
//   ALU_VALID/ALU_RD/ALU_WD/ALU_READY : ALU result offer and acceptance
//   MEM_VALID/MEM_RD/MEM_WD/MEM_READY : load-unit result offer and acceptance
//   WE3/RA3/WD3                       : registered write port to the register bank
//   PEND_MASK                         : registers with a write not yet in the bank
// Modport slave is used by the arbiter, master by whatever drives the producers.
interface wb_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic                ALU_VALID;
    logic [ADDR_W-1:0]   ALU_RD;
    logic [WIDTH-1:0]    ALU_WD;
    logic                ALU_READY;
    logic                MEM_VALID;
    logic [ADDR_W-1:0]   MEM_RD;
    logic [WIDTH-1:0]    MEM_WD;
    logic                MEM_READY;
    logic                WE3;
    logic [ADDR_W-1:0]   RA3;
    logic [WIDTH-1:0]    WD3;
    logic [NUM_REGS-1:0] PEND_MASK;

    modport slave (
        input  ALU_VALID, ALU_RD, ALU_WD, MEM_VALID, MEM_RD, MEM_WD,
        output ALU_READY, MEM_READY, WE3, RA3, WD3, PEND_MASK
    );

    modport master (
        output ALU_VALID, ALU_RD, ALU_WD, MEM_VALID, MEM_RD, MEM_WD,
        input  ALU_READY, MEM_READY, WE3, RA3, WD3, PEND_MASK
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and memory-unit results into the single register
// bank write port. Accepted writes go through a DEPTH-entry in-order FIFO and
// retire one per cycle onto WE3/RA3/WD3. PEND_MASK flags every register whose
// write is still buffered or currently presented to the bank.
// Ports:
//   CLK   : clock, all state changes on its rising edge
//   RST_N : synchronous active-low reset
//   bus   : wb_arbiter_if.slave (handshakes, bank write port, pending mask)
module wb_arbiter #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    wb_arbiter_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] rd_mem [DEPTH];
    logic [WIDTH-1:0]  wd_mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_next, wr_ptr_next, alu_slot;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              we_reg;
    logic [ADDR_W-1:0] ra_reg;
    logic [WIDTH-1:0]  wd_reg;

    logic ready, mem_acc, alu_acc, pop;

    // Both sources share one ready so that two simultaneous enqueues always fit.
    assign ready   = (count_reg <= CNT_W'(DEPTH - 2));
    assign mem_acc = bus.MEM_VALID & ready;
    assign alu_acc = bus.ALU_VALID & ready;
    // Pop decision uses the count before this edge's enqueues, so a freshly
    // written entry is never retired in the same cycle.
    assign pop     = (count_reg != '0);

    // MEM takes the first free slot, ALU the one after it when both transfer.
    assign alu_slot    = wr_ptr_reg + PTR_W'(mem_acc);
    assign wr_ptr_next = wr_ptr_reg + PTR_W'(mem_acc) + PTR_W'(alu_acc);
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    assign count_next  = count_reg + CNT_W'(mem_acc) + CNT_W'(alu_acc) - CNT_W'(pop);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            we_reg     <= 1'b0;
            ra_reg     <= '0;
            wd_reg     <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            if (pop) begin
                we_reg <= 1'b1;
                ra_reg <= rd_mem[rd_ptr_reg];
                wd_reg <= wd_mem[rd_ptr_reg];
            end else begin
                we_reg <= 1'b0;
            end
        end
    end

    // Storage has no reset; validity is defined by the pointers and count.
    // Write slots never collide with the head slot because acceptance
    // requires at least two free entries.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_acc && wr_ptr_reg == PTR_W'(i)) begin
                    rd_mem[i] <= bus.MEM_RD;
                    wd_mem[i] <= bus.MEM_WD;
                end else if (alu_acc && alu_slot == PTR_W'(i)) begin
                    rd_mem[i] <= bus.ALU_RD;
                    wd_mem[i] <= bus.ALU_WD;
                end
            end
        end
    end

    // A physical slot holds a live entry when its distance from the head,
    // taken modulo DEPTH, is below the occupancy count.
    logic [DEPTH-1:0][NUM_REGS-1:0] slot_mask;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] slot_off;
            logic             slot_valid;
            assign slot_off      = PTR_W'(gi) - rd_ptr_reg;
            assign slot_valid    = (CNT_W'(slot_off) < count_reg);
            assign slot_mask[gi] = slot_valid ? (NUM_REGS'(1) << rd_mem[gi]) : '0;
        end
    endgenerate

    logic [NUM_REGS-1:0] pend_mask;

    always_comb begin
        pend_mask = we_reg ? (NUM_REGS'(1) << ra_reg) : '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_mask = pend_mask | slot_mask[i];
        end
    end

    assign bus.ALU_READY = ready;
    assign bus.MEM_READY = ready;
    assign bus.WE3       = we_reg;
    assign bus.RA3       = ra_reg;
    assign bus.WD3       = wd_reg;
    assign bus.PEND_MASK = pend_mask;
endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus randomized traffic,
// compared against a queue-based model of the write-back path.
module tb_wb_arbiter;
    localparam int WIDTH    = 32;
    localparam int ADDR_W   = 4;
    localparam int DEPTH    = 4;
    localparam int NUM_REGS = 16;
    localparam int EW       = ADDR_W + WIDTH;

    logic CLK;
    logic RST_N;

    wb_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    wb_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of pending {rd, wd} plus the bank port.
    logic [EW-1:0]     mq[$];
    logic              m_we = 1'b0;
    logic [ADDR_W-1:0] m_ra = '0;
    logic [WIDTH-1:0]  m_wd = '0;
    logic              m_acc_a = 1'b0;
    logic              m_acc_m = 1'b0;

    // Observed bank traffic.
    logic [EW-1:0]     retired[$];
    logic [WIDTH-1:0]  dut_bank [NUM_REGS];

    function automatic logic [NUM_REGS-1:0] model_mask();
        logic [NUM_REGS-1:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i][EW-1:WIDTH]] = 1'b1;
        if (m_we) m[m_ra] = 1'b1;
        return m;
    endfunction

    function automatic logic model_ready();
        return (mq.size() <= DEPTH - 2);
    endfunction

    task automatic drive(input logic av, input logic [ADDR_W-1:0] ard, input logic [WIDTH-1:0] awd,
                         input logic mv, input logic [ADDR_W-1:0] mrd, input logic [WIDTH-1:0] mwd);
        bus.ALU_VALID = av; bus.ALU_RD = ard; bus.ALU_WD = awd;
        bus.MEM_VALID = mv; bus.MEM_RD = mrd; bus.MEM_WD = mwd;
    endtask

    // Advance one clock edge, update the model from the inputs seen at that
    // edge, then record what the DUT presents to the bank.
    task automatic step();
        logic [EW-1:0] e;
        logic          rdy;
        @(posedge CLK);
        m_acc_a = 1'b0;
        m_acc_m = 1'b0;
        if (!RST_N) begin
            mq.delete();
            m_we = 1'b0; m_ra = '0; m_wd = '0;
        end else begin
            rdy = model_ready();
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_we = 1'b1; m_ra = e[EW-1:WIDTH]; m_wd = e[WIDTH-1:0];
            end else begin
                m_we = 1'b0;
            end
            m_acc_m = rdy && bus.MEM_VALID;
            m_acc_a = rdy && bus.ALU_VALID;
            if (m_acc_m) mq.push_back({bus.MEM_RD, bus.MEM_WD});
            if (m_acc_a) mq.push_back({bus.ALU_RD, bus.ALU_WD});
        end
        #1;
        if (bus.WE3 === 1'b1) begin
            retired.push_back({bus.RA3, bus.WD3});
            dut_bank[bus.RA3] = bus.WD3;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        drive(1'b1, 4'd7, 32'hAAAA5555, 1'b1, 4'd9, 32'h12345678);
        step();
        step();
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3: got %b want 0", bus.WE3); end
        checks++; if (bus.RA3 !== 4'd0) begin errors++; $display("FAIL reset_ra3: got %0d want 0", bus.RA3); end
        checks++; if (bus.WD3 !== 32'd0) begin errors++; $display("FAIL reset_wd3: got %h want 0", bus.WD3); end
        checks++; if (bus.PEND_MASK !== 16'd0) begin errors++; $display("FAIL reset_pend: got %h want 0", bus.PEND_MASK); end
        checks++; if ({bus.ALU_READY, bus.MEM_READY} !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b%b want 11", bus.ALU_READY, bus.MEM_READY); end
        RST_N = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        step();
        checks++; if ({bus.WE3, bus.PEND_MASK} !== 17'd0) begin errors++; $display("FAIL reset_no_enqueue: got we=%b pend=%h want we=0 pend=0", bus.WE3, bus.PEND_MASK); end
        $display("test_reset done");
    endtask

    task automatic test_single_latency();
        drive(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
        step();  // edge E
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        checks++; if ({bus.WE3, bus.PEND_MASK} !== {1'b0, 16'h0020}) begin errors++; $display("FAIL single_after_E: got we=%b pend=%h want we=0 pend=0020", bus.WE3, bus.PEND_MASK); end
        step();  // E+1
        checks++; if ({bus.WE3, bus.RA3, bus.WD3} !== {1'b1, 4'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL single_port: got we=%b ra=%0d wd=%h want we=1 ra=5 wd=deadbeef", bus.WE3, bus.RA3, bus.WD3); end
        checks++; if (bus.PEND_MASK !== 16'h0020) begin errors++; $display("FAIL single_pend_E1: got %h want 0020", bus.PEND_MASK); end
        step();  // E+2
        checks++; if ({bus.WE3, bus.PEND_MASK} !== 17'd0) begin errors++; $display("FAIL single_after_E2: got we=%b pend=%h want we=0 pend=0", bus.WE3, bus.PEND_MASK); end
        $display("test_single_latency done");
    endtask

    task automatic test_collision();
        drive(1'b1, 4'd3, 32'h22, 1'b1, 4'd3, 32'h11);
        step();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        step();
        checks++; if ({bus.WE3, bus.RA3, bus.WD3} !== {1'b1, 4'd3, 32'h11}) begin errors++; $display("FAIL collision_first: got we=%b ra=%0d wd=%h want we=1 ra=3 wd=11", bus.WE3, bus.RA3, bus.WD3); end
        step();
        checks++; if ({bus.WE3, bus.RA3, bus.WD3} !== {1'b1, 4'd3, 32'h22}) begin errors++; $display("FAIL collision_second: got we=%b ra=%0d wd=%h want we=1 ra=3 wd=22", bus.WE3, bus.RA3, bus.WD3); end
        step();
        checks++; if (bus.WE3 !== 1'b0) begin errors++; $display("FAIL collision_idle: got we=%b want 0", bus.WE3); end
        checks++; if (dut_bank[3] !== 32'h22) begin errors++; $display("FAIL collision_bank: got %h want 22", dut_bank[3]); end
        $display("test_collision done");
    endtask

    task automatic test_backpressure();
        int  ma = 0;
        int  aa = 0;
        logic saw_low = 1'b0;
        logic [EW-1:0] exp_e;
        retired.delete();
        for (int cyc = 0; cyc < 200 && retired.size() < 16; cyc++) begin
            drive(aa < 8, 4'(aa), 32'h2000 + aa, ma < 8, 4'(ma), 32'h1000 + ma);
            if (bus.ALU_READY === 1'b0) saw_low = 1'b1;
            step();
            if (m_acc_a) aa++;
            if (m_acc_m) ma++;
            checks++;
            if ({bus.WE3, bus.RA3, bus.WD3, bus.PEND_MASK, bus.ALU_READY, bus.MEM_READY} !==
                {m_we, m_ra, m_wd, model_mask(), model_ready(), model_ready()}) begin
                errors++;
                $display("FAIL backpressure_cyc%0d: got we=%b ra=%0d wd=%h pend=%h rdy=%b%b want we=%b ra=%0d wd=%h pend=%h rdy=%b",
                         cyc, bus.WE3, bus.RA3, bus.WD3, bus.PEND_MASK, bus.ALU_READY, bus.MEM_READY,
                         m_we, m_ra, m_wd, model_mask(), model_ready());
            end
        end
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        checks++; if (saw_low !== 1'b1) begin errors++; $display("FAIL backpressure_ready_low: got never-low want low-seen"); end
        checks++; if (retired.size() != 16) begin errors++; $display("FAIL backpressure_count: got %0d retired want 16", retired.size()); end
        for (int i = 0; i < 16 && i < retired.size(); i++) begin
            exp_e = (i % 2 == 0) ? {4'(i / 2), 32'h1000 + i / 2} : {4'(i / 2), 32'h2000 + i / 2};
            checks++;
            if (retired[i] !== exp_e) begin errors++; $display("FAIL backpressure_order[%0d]: got %h want %h", i, retired[i], exp_e); end
        end
        step();
        $display("test_backpressure done");
    endtask

    task automatic test_wraparound();
        logic [EW-1:0] exp_e;
        retired.delete();
        for (int i = 0; i < 14; i++) begin
            if (i < 10 && i % 2 == 0) drive(1'b1, 4'(i), 32'(i) * 32'h100, 1'b0, 4'd0, 32'd0);
            else if (i < 10)          drive(1'b0, 4'd0, 32'd0, 1'b1, 4'(i), 32'(i) * 32'h100);
            else                      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
            step();
            checks++;
            if ({bus.WE3, bus.RA3, bus.WD3, bus.PEND_MASK, bus.ALU_READY} !==
                {m_we, m_ra, m_wd, model_mask(), model_ready()}) begin
                errors++;
                $display("FAIL wrap_cyc%0d: got we=%b ra=%0d wd=%h pend=%h rdy=%b want we=%b ra=%0d wd=%h pend=%h rdy=%b",
                         i, bus.WE3, bus.RA3, bus.WD3, bus.PEND_MASK, bus.ALU_READY,
                         m_we, m_ra, m_wd, model_mask(), model_ready());
            end
        end
        checks++; if (retired.size() != 10) begin errors++; $display("FAIL wrap_count: got %0d want 10", retired.size()); end
        for (int i = 0; i < 10 && i < retired.size(); i++) begin
            exp_e = {4'(i), 32'(i) * 32'h100};
            checks++;
            if (retired[i] !== exp_e) begin errors++; $display("FAIL wrap_order[%0d]: got %h want %h", i, retired[i], exp_e); end
        end
        $display("test_wraparound done");
    endtask

    task automatic test_reset_mid_drain();
        drive(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hB2);
        step();
        drive(1'b1, 4'd6, 32'hA6, 1'b1, 4'd8, 32'hB8);
        step();
        checks++; if (bus.PEND_MASK !== model_mask()) begin errors++; $display("FAIL middrain_fill: got pend=%h want %h", bus.PEND_MASK, model_mask()); end
        drive(1'b1, 4'd4, 32'hC4, 1'b1, 4'd4, 32'hD4);
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        checks++; if ({bus.WE3, bus.PEND_MASK, bus.ALU_READY, bus.MEM_READY} !== {1'b0, 16'd0, 2'b11}) begin
            errors++;
            $display("FAIL middrain_reset: got we=%b pend=%h rdy=%b%b want we=0 pend=0 rdy=11", bus.WE3, bus.PEND_MASK, bus.ALU_READY, bus.MEM_READY);
        end
        retired.delete();
        for (int i = 0; i < 4; i++) step();
        checks++; if (retired.size() != 0 || bus.PEND_MASK !== 16'd0) begin
            errors++;
            $display("FAIL middrain_after: got %0d retirements pend=%h want 0 retirements pend=0", retired.size(), bus.PEND_MASK);
        end
        $display("test_reset_mid_drain done");
    endtask

    task automatic test_random();
        logic              a_pend = 1'b0, m_pend = 1'b0;
        logic [ADDR_W-1:0] a_rd = '0, m_rd = '0;
        logic [WIDTH-1:0]  a_wd = '0, m_wd_r = '0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (cyc < 400) begin
                if (!a_pend && $urandom_range(2) != 0) begin a_pend = 1'b1; a_rd = 4'($urandom); a_wd = $urandom; end
                if (!m_pend && $urandom_range(2) != 0) begin m_pend = 1'b1; m_rd = 4'($urandom); m_wd_r = $urandom; end
            end
            drive(a_pend, a_rd, a_wd, m_pend, m_rd, m_wd_r);
            step();
            if (m_acc_a) a_pend = 1'b0;
            if (m_acc_m) m_pend = 1'b0;
            checks++;
            if ({bus.WE3, bus.RA3, bus.WD3, bus.PEND_MASK, bus.ALU_READY, bus.MEM_READY} !==
                {m_we, m_ra, m_wd, model_mask(), model_ready(), model_ready()}) begin
                errors++;
                $display("FAIL random_cyc%0d: got we=%b ra=%0d wd=%h pend=%h rdy=%b%b want we=%b ra=%0d wd=%h pend=%h rdy=%b",
                         cyc, bus.WE3, bus.RA3, bus.WD3, bus.PEND_MASK, bus.ALU_READY, bus.MEM_READY,
                         m_we, m_ra, m_wd, model_mask(), model_ready());
            end
        end
        checks++; if (a_pend || m_pend || mq.size() != 0) begin errors++; $display("FAIL random_drain: got a_pend=%b m_pend=%b queued=%0d want all 0", a_pend, m_pend, mq.size()); end
        $display("test_random done");
    endtask

    initial begin
        RST_N = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        foreach (dut_bank[i]) dut_bank[i] = '0;
        test_reset();
        test_single_latency();
        test_collision();
        test_backpressure();
        test_wraparound();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that sits directly upstream of the register bank and drives its single write port (WE3/RA3/WD3). Two result producers, the single-cycle ALU and the multi-cycle memory/load unit, each offer a write through a valid/ready handshake. Accepted writes are buffered in a small in-order FIFO and retired at one per cycle. A pending-write mask is exported so that decode/hazard logic can stall on registers whose write has not yet reached the bank.

## Interface
Parameters:
- WIDTH, 32, data word width (matches register bank WIDTH).
- ADDR_W, 4, register address width. Register count NUM_REGS = 2**ADDR_W.
- DEPTH, 4, FIFO entries. Must be a power of two and ≥ 2.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST_N  input  1  reset: synchronous, active-low.
- ALU_VALID  input  1  ALU offers a write this cycle.
- ALU_RD  input  ADDR_W  ALU destination register.
- ALU_WD  input  WIDTH  ALU result.
- ALU_READY  output  1  arbiter can accept an ALU write.
- MEM_VALID  input  1  memory unit offers a write this cycle.
- MEM_RD  input  ADDR_W  memory destination register.
- MEM_WD  input  WIDTH  load data.
- MEM_READY  output  1  arbiter can accept a memory write.
- WE3  output  1  register bank write enable (registered).
- RA3  output  ADDR_W  register bank write address (registered).
- WD3  output  WIDTH  register bank write data (registered).
- PEND_MASK  output  NUM_REGS  bit r = 1 while a write to r is buffered or presented on WE3/RA3.

## Operation
- **Handshake:**
  - A transfer occurs on a source when VALID && READY at a rising edge.
  - VALID while READY = 0 is ignored. The source holds its request.
  - READY is a function of registered state only. It never depends on either VALID.
- **FIFO:**
  - DEPTH entries of {rd, wd}, with read pointer, write pointer and occupancy count.
  - Pointers wrap modulo DEPTH.
  - Count width is clog2(DEPTH+1).
- **Enqueue:**
  - Up to two entries per cycle.
  - When both sources transfer in the same cycle, the MEM entry goes first and the ALU entry second.
  - So for the same rd, the ALU value is the one finally held in the bank.
- **Ready rule:** ALU_READY = MEM_READY = (count ≤ DEPTH−2). Both are always equal, which guarantees room for two simultaneous enqueues.
- **Drain:**
  - Each edge with count > 0 (count before this edge's enqueues), the head is popped into WE3/RA3/WD3 with WE3 = 1.
  - Each edge with count = 0, WE3 ← 0, and RA3/WD3 hold their previous values.
- **Simultaneous events:**
  - Enqueue and pop in the same edge are allowed.
  - Next count = count + accepted − popped.
  - An entry enqueued at an edge cannot be popped at that same edge.
- **PEND_MASK:**
  - Combinational: the OR over valid FIFO entries of onehot(rd), OR'd with onehot(RA3) when WE3 = 1.
  - Duplicated rd values give a single set bit.
- No register is special; writes to register 0 are retired like any other.
- **Reset (RST_N = 0 at an edge):**
  - count, both pointers, WE3, RA3 and WD3 are cleared to 0.
  - Buffered entries are discarded, including in the middle of a drain.
  - The VALID inputs sampled at that edge are ignored.
  - Resulting outputs: ALU_READY = MEM_READY = 1, PEND_MASK = 0.

## Timing
- Write accepted at edge E into an empty FIFO → WE3 = 1 with that RA3/WD3 after edge E+1 → register bank stores it at edge E+2.
- Two writes accepted at edge E into an empty FIFO:
  - MEM entry presented after E+1.
  - ALU entry presented after E+2.
  - WE3 drops after E+3 if nothing else arrives.
- Sustained throughput is one retired write per cycle.
- **Backpressure:**
  - READY falls in the cycle after count first exceeds DEPTH−2.
  - It rises in the cycle after a pop brings count back to ≤ DEPTH−2.
- PEND_MASK updates in the same cycle that the state changes (no extra latency).
- Bit r of PEND_MASK clears in the cycle after the bank write edge of the last pending write to r.

## Test plan
1. **Reset values:** assert RST_N = 0 for 2 cycles with both VALIDs high → WE3 = 0, RA3 = 0, WD3 = 0, PEND_MASK = 0, both READYs = 1, and nothing is enqueued.
2. **Single write latency:** ALU_VALID for 1 cycle with RD = 5, WD = 0xDEADBEEF at edge E → WE3 = 1, RA3 = 5, WD3 = 0xDEADBEEF after E+1 only; PEND_MASK[5] = 1 from after E until after E+2.
3. **Same-rd collision:** MEM (RD 3, 0x11) and ALU (RD 3, 0x22) at the same edge → RA3/WD3 sequence is 3/0x11 then 3/0x22; bank register 3 ends at 0x22.
4. **Backpressure with DEPTH = 4:** both sources valid every cycle → READY drops when count reaches 3; no write is lost or duplicated; retired order is M0, A0, M1, A1, …
5. **Wrap-around:** 10 alternating single ALU/MEM writes with RD = i, WD = i·0x100 → 10 retirements in order with the correct data after both pointers wrap twice.
6. **Reset mid-drain:** buffer 3 entries, pulse RST_N low for one edge → WE3 = 0 after that edge, no further retirements, PEND_MASK = 0.
